seg_scan: RTL
=============

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SCAN_DIV, 50000, clk cycles per digit slot; legal range 2..65535.
REQ-002 clk  input  1  single clock for all state, rising-edge triggered.
REQ-003 KEY0  input  1  reset, asynchronous and active-low; asserting it forces reset state immediately, deassertion is synchronous to clk.
REQ-004 data_in  input  16  four hex nibbles; nibble k drives digit k (digit 0 = bits 3:0).
REQ-005 data_valid  input  1  producer offers data_in this cycle.
REQ-006 data_ready  output  1  block can accept data_in this cycle.
REQ-007 blank_lz  input  1  leading-zero blanking enable, sampled every cycle.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 dig_en  output  4  digit enables, active-low, one-hot-low or all-high, registered.

Function
REQ-010 div_cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; idx (2 bits) SHALL increment, mod 4, in the cycle div_cnt == SCAN_DIV-1.
REQ-011 Frame boundary = cycle with div_cnt == SCAN_DIV-1 and idx == 3; one frame = 4*SCAN_DIV cycles.
REQ-012 Handshake: transfer occurs when data_valid && data_ready at a rising clk edge; data_ready = NOT pend_full, a register output.
REQ-013 On transfer: pend <= data_in, pend_full <= 1; data_ready low from the next cycle.
REQ-014 At frame boundary with pend_full = 1: disp <= pend, pend_full <= 0; data_ready high from the next cycle; new value first visible on digit 0 of the next frame, no tearing within a frame.
REQ-015 Transfer at a frame boundary with pend empty: captured into pend only, shown after the following boundary; no bypass path.
REQ-016 data_valid while data_ready = 0: ignored, no state change; producer holds data.
REQ-017 Output registers update every cycle from current state (1-cycle latency): if div_cnt == 0 then dig_en <= 4'hF (dead time, exactly 1 cycle per slot), else dig_en <= all-high except bit idx low.
REQ-018 seg <= hex encoding of disp nibble idx: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,B=03,C=46,D=21,E=06,F=0E (hex, 7-bit).
REQ-019 Blanking: when blank_lz = 1 and every disp nibble at index >= idx is 0 and idx != 0, seg <= 7'h7F; dig_en unaffected; digit 0 is never blanked.
REQ-020 During dead-time cycles seg SHALL still carry the encoding of the current idx (don't-care for display, deterministic for checking).

Reset
REQ-021 While KEY0 = 0: div_cnt = 0, idx = 0, disp = 16'h0000, pend = 0, pend_full = 0, data_ready = 1, seg = 7'h7F, dig_en = 4'hF.
REQ-022 Reset mid-frame or with pend_full = 1 SHALL discard pend and disp; no partial transfer.
REQ-023 First edge after release: outputs dark (dig_en = F, div_cnt 0 sampled); second edge: dig_en = 4'b1110, seg = 7'h40.

Verification (SCAN_DIV = 4, frame = 16 cycles)
REQ-024 KEY0 low for 3 cycles then high -> seg 7F, dig_en F, data_ready 1 during reset; 2 edges after release dig_en 1110, seg 40.
REQ-025 data_in 16'h20A1 with data_valid for 1 cycle -> data_ready 0 next cycle until the frame boundary; next frame digits 0..3 show seg 79, 08, 40, 24 with dig_en 1110, 1101, 1011, 0111.
REQ-026 data_valid held with 16'h1111 while data_ready = 0 -> not accepted until data_ready = 1; then one transfer only, shown one frame later.
REQ-027 blank_lz = 1, load 16'h000F -> digit 0 seg 0E, digits 1..3 seg 7F; load 16'h0000 -> digit 0 seg 40 only; blank_lz = 0 -> all digits show 40.
REQ-028 KEY0 pulsed low mid-frame with pend_full = 1 -> outputs immediately 7F/F, data_ready 1, after release display shows 0000.
REQ-029 Over 3 frames: exactly one dead-time cycle per 4-cycle slot; dig_en never has more than one bit low.

Source files
------------

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - four-digit multiplexed hex display scanner
// Pending/display double buffer with valid/ready load, swapped only at frame boundaries.
module seg_scan #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        KEY0,
   input  logic [15:0] data_in,
   input  logic        data_valid,
   output logic        data_ready,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic [3:0]  dig_en
);

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

   logic [15:0] div_cnt;
   logic [1:0]  idx;
   logic [15:0] disp;
   logic [15:0] pend;
   logic        pend_full;

   logic        slot_end;
   logic        frame_end;
   logic        take;
   logic [3:0]  nibble;
   logic        upper_zero;
   logic [6:0]  seg_code;
   logic [6:0]  seg_next;
   logic [3:0]  dig_next;

   assign slot_end   = (div_cnt == DIV_LAST);
   assign frame_end  = slot_end && (idx == 2'd3);
   assign data_ready = ~pend_full;
   assign take       = data_valid && data_ready;

   // scan timebase
   always_ff @(posedge clk or negedge KEY0) begin
      if (!KEY0) begin
         div_cnt <= '0;
         idx     <= '0;
      end else begin
         if (slot_end) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
         end else begin
            div_cnt <= div_cnt + 16'd1;
         end
      end
   end

   // a full pend blocks the handshake, so a boundary swap and a capture never coincide
   always_ff @(posedge clk or negedge KEY0) begin
      if (!KEY0) begin
         disp      <= '0;
         pend      <= '0;
         pend_full <= 1'b0;
      end else begin
         if (frame_end && pend_full) begin
            disp      <= pend;
            pend_full <= 1'b0;
         end else if (take) begin
            pend      <= data_in;
            pend_full <= 1'b1;
         end
      end
   end

   always_comb begin
      nibble = disp[{idx, 2'b00} +: 4];
      upper_zero = 1'b0;
      case (idx)
         2'd1:    upper_zero = (disp[15:4] == 12'h000);
         2'd2:    upper_zero = (disp[15:8] == 8'h00);
         2'd3:    upper_zero = (disp[15:12] == 4'h0);
         default: upper_zero = 1'b0;
      endcase
   end

   always_comb begin
      seg_code = 7'h7F;
      case (nibble)
         4'h0: seg_code = 7'h40;
         4'h1: seg_code = 7'h79;
         4'h2: seg_code = 7'h24;
         4'h3: seg_code = 7'h30;
         4'h4: seg_code = 7'h19;
         4'h5: seg_code = 7'h12;
         4'h6: seg_code = 7'h02;
         4'h7: seg_code = 7'h78;
         4'h8: seg_code = 7'h00;
         4'h9: seg_code = 7'h10;
         4'hA: seg_code = 7'h08;
         4'hB: seg_code = 7'h03;
         4'hC: seg_code = 7'h46;
         4'hD: seg_code = 7'h21;
         4'hE: seg_code = 7'h06;
         4'hF: seg_code = 7'h0E;
         default: seg_code = 7'h7F;
      endcase
   end

   // the first cycle of every slot is dead time to avoid ghosting between digits
   always_comb begin
      seg_next = (blank_lz && upper_zero) ? 7'h7F : seg_code;
      dig_next = (div_cnt == 16'd0) ? 4'hF : ~(4'b0001 << idx);
   end

   always_ff @(posedge clk or negedge KEY0) begin
      if (!KEY0) begin
         seg    <= 7'h7F;
         dig_en <= 4'hF;
      end else begin
         seg    <= seg_next;
         dig_en <= dig_next;
      end
   end

endmodule
